sid_voice_core: RTL and testbench



---
 rtl/sid_voice_core.sv | 247 ++++++++++++++++++++++++
 tb/tb_sid_voice_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sid_voice_core.sv
// sid_voice_core: simplified three-voice SID with oscillators, waveforms, ADSR envelopes,
// an unfiltered mixer and master volume; voice state advances only on the 1 MHz clk_en.
module sid_voice_core (
  input  logic        sysclk,
  input  logic        n_reset,
  input  logic        clk_en,
  input  logic [4:0]  addr,
  input  logic [7:0]  data,
  input  logic        n_cs,
  input  logic        rw,
  output logic [7:0]  data_out,
  output logic [15:0] audio_out
);

  localparam int unsigned NV     = 3;
  localparam int unsigned NREG   = 25;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned LFSR_W = 23;
  localparam int unsigned WAVE_W = 12;
  localparam int unsigned ENV_W  = 8;
  localparam int unsigned PROD_W = WAVE_W + ENV_W;
  localparam int unsigned RCNT_W = 15;
  localparam int unsigned ECNT_W = 5;
  localparam int unsigned SUM_W  = 14;
  localparam int unsigned MIX_W  = 18;
  localparam int unsigned AUD_W  = 16;
  localparam logic [LFSR_W-1:0] LFSR_SEED = '1;

  typedef enum logic [1:0] {ATTACK, DECAY, RELEASE} env_state_t;

  function automatic logic [RCNT_W-1:0] rate_period(input logic [3:0] r);
    case (r)
      4'd0:    return 15'd9;
      4'd1:    return 15'd32;
      4'd2:    return 15'd63;
      4'd3:    return 15'd95;
      4'd4:    return 15'd149;
      4'd5:    return 15'd220;
      4'd6:    return 15'd267;
      4'd7:    return 15'd313;
      4'd8:    return 15'd392;
      4'd9:    return 15'd977;
      4'd10:   return 15'd1954;
      4'd11:   return 15'd3126;
      4'd12:   return 15'd3907;
      4'd13:   return 15'd11720;
      4'd14:   return 15'd19532;
      default: return 15'd31251;
    endcase
  endfunction

  // Piecewise-exponential slowdown of decay/release as the level falls
  function automatic logic [ECNT_W-1:0] exp_div(input logic [ENV_W-1:0] e);
    if (e > 8'd93)      return 5'd1;
    else if (e > 8'd54) return 5'd2;
    else if (e > 8'd26) return 5'd4;
    else if (e > 8'd14) return 5'd8;
    else if (e > 8'd6)  return 5'd16;
    else                return 5'd30;
  endfunction

  logic [7:0] regs [NREG];

  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (!n_cs && !rw && (addr < 5'(NREG))) begin
      regs[addr] <= data;
    end
  end

  logic [3:0] vol;
  logic       v3off;
  assign vol   = regs[24][3:0];
  assign v3off = regs[24][7];

  logic [NV-1:0]     acc_msb;
  logic [NV-1:0]     sum_msb;
  logic [NV-1:0]     test_bit;
  logic [WAVE_W-1:0] wave    [NV];
  logic [ENV_W-1:0]  env_lvl [NV];
  logic [WAVE_W-1:0] vout    [NV];

  for (genvar v = 0; v < NV; v++) begin : g_voice
    localparam int unsigned BASE = 7 * v;
    localparam int unsigned SRC  = (v + NV - 1) % NV;

    logic [15:0]       freq;
    logic [11:0]       pw;
    logic [7:0]        ctrl;
    logic [7:0]        ad;
    logic [7:0]        sr;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              src_rose;
    logic [WAVE_W-1:0] saw, tri_w, pulse, noise, wave_c;
    env_state_t        st_q, st_d;
    logic [ENV_W-1:0]  env_q, env_d, sus_lvl;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d, period;
    logic [ECNT_W-1:0] ecnt_q, ecnt_d, ediv;
    logic [3:0]        rate;
    logic              gate_q, step, can_fall;
    logic [PROD_W-1:0] prod;

    assign freq = {regs[BASE+1], regs[BASE]};
    assign pw   = {regs[BASE+3][3:0], regs[BASE+2]};
    assign ctrl = regs[BASE+4];
    assign ad   = regs[BASE+5];
    assign sr   = regs[BASE+6];

    assign acc_sum     = acc_q + ACC_W'(freq);
    assign acc_msb[v]  = acc_q[ACC_W-1];
    assign sum_msb[v]  = acc_sum[ACC_W-1];
    assign test_bit[v] = ctrl[3];
    // Source MSB edge taken from its free-running sum so voices never form a comb loop
    assign src_rose    = ~test_bit[SRC] & ~acc_msb[SRC] & sum_msb[SRC];

    always_comb begin
      acc_d  = acc_q;
      lfsr_d = lfsr_q;
      if (clk_en) begin
        if (ctrl[3]) begin
          acc_d  = '0;
          lfsr_d = LFSR_SEED;
        end else begin
          acc_d = (ctrl[1] && src_rose) ? '0 : acc_sum;
          if (!acc_q[19] && acc_d[19])
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[22] ^ lfsr_q[17]};
        end
      end
    end

    assign saw   = acc_q[ACC_W-1:ACC_W-WAVE_W];
    assign tri_w = acc_q[ACC_W-2:ACC_W-WAVE_W-1] ^ {WAVE_W{acc_q[ACC_W-1] ^ (ctrl[2] & acc_msb[SRC])}};
    assign pulse = (saw >= pw) ? '1 : '0;
    assign noise = {lfsr_q[22], lfsr_q[20], lfsr_q[16], lfsr_q[13],
                    lfsr_q[11], lfsr_q[7], lfsr_q[4], lfsr_q[2], 4'b0000};

    always_comb begin
      wave_c = '1;
      if (ctrl[4]) wave_c = wave_c & tri_w;
      if (ctrl[5]) wave_c = wave_c & saw;
      if (ctrl[6]) wave_c = wave_c & pulse;
      if (ctrl[7]) wave_c = wave_c & noise;
      if (ctrl[7:4] == 4'b0000) wave_c = '0;
    end

    assign sus_lvl = {sr[7:4], sr[7:4]};
    assign ediv    = exp_div(env_q);

    // Envelope next-state: gate edges switch phase at once, steps move the level
    always_comb begin
      st_d     = st_q;
      env_d    = env_q;
      rcnt_d   = rcnt_q;
      ecnt_d   = ecnt_q;
      step     = 1'b0;
      can_fall = 1'b0;
      rate     = sr[3:0];
      if (st_q == ATTACK)     rate = ad[7:4];
      else if (st_q == DECAY) rate = ad[3:0];
      period = rate_period(rate);
      if (clk_en) begin
        if (rcnt_q >= period - RCNT_W'(1)) begin
          rcnt_d = '0;
          step   = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
      if (ctrl[0] && !gate_q) begin
        st_d = ATTACK;
      end else if (!ctrl[0] && gate_q) begin
        st_d = RELEASE;
      end else if (step) begin
        case (st_q)
          ATTACK: begin
            ecnt_d = '0;
            if (env_q != '1) env_d = env_q + ENV_W'(1);
            if (env_q >= 8'hFE) st_d = DECAY;
          end
          DECAY, RELEASE: begin
            can_fall = (st_q == DECAY) ? (env_q > sus_lvl) : (env_q != '0);
            if (can_fall) begin
              if (ecnt_q >= ediv - ECNT_W'(1)) begin
                ecnt_d = '0;
                env_d  = env_q - ENV_W'(1);
              end else begin
                ecnt_d = ecnt_q + ECNT_W'(1);
              end
            end
          end
          default: st_d = RELEASE;
        endcase
      end
    end

    always_ff @(posedge sysclk or negedge n_reset) begin
      if (!n_reset) begin
        acc_q  <= '0;
        lfsr_q <= LFSR_SEED;
        st_q   <= RELEASE;
        env_q  <= '0;
        rcnt_q <= '0;
        ecnt_q <= '0;
        gate_q <= 1'b0;
      end else begin
        acc_q  <= acc_d;
        lfsr_q <= lfsr_d;
        st_q   <= st_d;
        env_q  <= env_d;
        rcnt_q <= rcnt_d;
        ecnt_q <= ecnt_d;
        gate_q <= ctrl[0];
      end
    end

    assign wave[v]    = wave_c;
    assign env_lvl[v] = env_q;
    assign prod       = PROD_W'(wave_c) * PROD_W'(env_q);
    assign vout[v]    = WAVE_W'(prod >> ENV_W);
  end

  logic [SUM_W-1:0] sum_c;
  logic [MIX_W-1:0] mix_c;
  assign sum_c = SUM_W'(vout[0]) + SUM_W'(vout[1]) + (v3off ? SUM_W'(0) : SUM_W'(vout[2]));
  assign mix_c = MIX_W'(sum_c) * MIX_W'(vol);

  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) audio_out <= '0;
    else          audio_out <= AUD_W'(mix_c >> 2);
  end

  // Only the voice-3 monitors are readable; everything else reads as zero
  always_ff @(posedge sysclk or negedge n_reset) begin
    if (!n_reset) begin
      data_out <= '0;
    end else if (!n_cs && rw) begin
      case (addr)
        5'h1B:   data_out <= wave[NV-1][WAVE_W-1:4];
        5'h1C:   data_out <= env_lvl[NV-1];
        default: data_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sid_voice_core.sv
// tb_sid_voice_core: scoreboard bench for sid_voice_core covering reset, saw, attack,
// decay/release, voice-3 readback and mute, pulse/test and hard sync.
module tb_sid_voice_core;

  logic        sysclk = 1'b0;
  logic        n_reset;
  logic        clk_en;
  logic [4:0]  addr;
  logic [7:0]  data;
  logic        n_cs;
  logic        rw;
  logic [7:0]  data_out;
  logic [15:0] audio_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned en_cnt   = 0;
  string       tag_q[$];
  int unsigned exp_q[$];

  sid_voice_core dut (
    .sysclk    (sysclk),
    .n_reset   (n_reset),
    .clk_en    (clk_en),
    .addr      (addr),
    .data      (data),
    .n_cs      (n_cs),
    .rw        (rw),
    .data_out  (data_out),
    .audio_out (audio_out)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned saw_of(input int unsigned n, input int unsigned f);
    longint unsigned a;
    a = (64'(n) * 64'(f)) % 64'h100_0000;
    return int'(a >> 12);
  endfunction

  function automatic int unsigned att_env(input int unsigned n);
    return (n / 9 > 255) ? 255 : n / 9;
  endfunction

  function automatic int unsigned mix(input int unsigned w0, input int unsigned e0,
                                      input int unsigned w2, input int unsigned e2,
                                      input bit v3off, input int unsigned vol);
    int unsigned s;
    s = ((w0 * e0) >> 8) + (v3off ? 0 : ((w2 * e2) >> 8));
    return (s * vol) >> 2;
  endfunction

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge sysclk);
    n_cs = 1'b0; rw = 1'b0; addr = a; data = d;
    @(negedge sysclk);
    n_cs = 1'b1; rw = 1'b1;
  endtask

  task automatic run(input int unsigned n);
    if (n > 0) begin
      @(negedge sysclk);
      clk_en = 1'b1;
      repeat (n) @(negedge sysclk);
      clk_en = 1'b0;
      en_cnt += n;
    end
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    n_reset = 1'b0; clk_en = 1'b0; n_cs = 1'b1; rw = 1'b1;
    @(negedge sysclk);
    n_reset = 1'b1;
    en_cnt  = 0;
  endtask

  // Read: expectation queued at issue, popped when data_out is valid one edge later
  task automatic rd_check(input logic [4:0] a, input string tag, input int unsigned exp);
    @(negedge sysclk);
    n_cs = 1'b0; rw = 1'b1; addr = a;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    @(negedge sysclk);
    n_cs = 1'b1;
    check_eq(tag_q.pop_front(), data_out, exp_q.pop_front());
  endtask

  task automatic audio_check(input string tag, input int unsigned exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    repeat (2) @(negedge sysclk);
    check_eq(tag_q.pop_front(), audio_out, exp_q.pop_front());
  endtask

  task automatic reset_pulse_check(input string tag);
    @(negedge sysclk);
    n_reset = 1'b0;
    #2;
    check_eq({tag, "_audio"}, audio_out, 0);
    check_eq({tag, "_dout"}, data_out, 0);
    @(negedge sysclk);
    n_reset = 1'b1;
    en_cnt  = 0;
  endtask

  initial begin
    n_reset = 1'b0; clk_en = 1'b0; n_cs = 1'b1; rw = 1'b1; addr = '0; data = '0;
    repeat (3) @(negedge sysclk);
    check_eq("rst_audio", audio_out, 0);
    check_eq("rst_dout", data_out, 0);
    n_reset = 1'b1;
    rd_check(5'h1C, "rst_env3", 0);
    rd_check(5'h1B, "rst_wave3", 0);

    // Saw on voice 3, FREQ=0x0100
    wr(5'd14, 8'h00); wr(5'd15, 8'h01); wr(5'd18, 8'h20);
    run(1280);
    rd_check(5'h1B, "saw_1280", saw_of(en_cnt, 32'h100) >> 4);
    repeat (20) @(negedge sysclk);
    rd_check(5'h1B, "saw_hold", saw_of(en_cnt, 32'h100) >> 4);
    run(256);
    rd_check(5'h1B, "saw_1536", saw_of(en_cnt, 32'h100) >> 4);

    // Attack on voice 0, sustain 15, full volume
    do_reset();
    wr(5'h18, 8'h0F); wr(5'd0, 8'h00); wr(5'd1, 8'h01);
    wr(5'd5, 8'h00); wr(5'd6, 8'hF0); wr(5'd4, 8'h21);
    run(900);
    audio_check("att_900", mix(saw_of(en_cnt, 32'h100), att_env(en_cnt), 0, 0, 1'b0, 15));
    run(1394);
    audio_check("att_2294", mix(saw_of(en_cnt, 32'h100), 254, 0, 0, 1'b0, 15));
    run(1);
    audio_check("att_2295", mix(saw_of(en_cnt, 32'h100), 255, 0, 0, 1'b0, 15));
    run(100);
    audio_check("att_hold", mix(saw_of(en_cnt, 32'h100), 255, 0, 0, 1'b0, 15));
    reset_pulse_check("midnote_rst");
    rd_check(5'h1C, "midnote_env3", 0);

    // Decay to sustain 8 (level 136) then release on voice 3, FREQ=0xFFFF
    do_reset();
    wr(5'h18, 8'h0F); wr(5'd14, 8'hFF); wr(5'd15, 8'hFF);
    wr(5'd19, 8'h00); wr(5'd20, 8'h80); wr(5'd18, 8'h21);
    run(2295);
    rd_check(5'h1C, "env3_peak", 255);
    run(450);
    rd_check(5'h1C, "env3_decay", 205);
    run(655);
    rd_check(5'h1C, "env3_sus", 136);
    run(200);
    rd_check(5'h1C, "env3_sus_hold", 136);
    rd_check(5'h1B, "wave3_rd", saw_of(en_cnt, 32'hFFFF) >> 4);
    audio_check("mix_v3on", mix(0, 0, saw_of(en_cnt, 32'hFFFF), 136, 1'b0, 15));
    wr(5'h18, 8'h8F);
    audio_check("mix_v3off", mix(0, 0, saw_of(en_cnt, 32'hFFFF), 136, 1'b1, 15));
    wr(5'h18, 8'h0F);
    wr(5'd18, 8'h20);
    run(387);
    rd_check(5'h1C, "rel_93", 93);
    run(702);
    rd_check(5'h1C, "rel_54", 54);
    run(1008);
    rd_check(5'h1C, "rel_26", 26);
    run(3635);
    rd_check(5'h1C, "rel_1", 1);
    run(1);
    rd_check(5'h1C, "rel_0", 0);
    run(1000);
    rd_check(5'h1C, "rel_nowrap", 0);

    // Pulse at 50% duty and the test bit, voice 3, FREQ=0x8000, PW=0x800
    do_reset();
    wr(5'd14, 8'h00); wr(5'd15, 8'h80); wr(5'd16, 8'h00); wr(5'd17, 8'h08);
    wr(5'd18, 8'h40);
    run(100);
    rd_check(5'h1B, "pulse_lo", (saw_of(en_cnt, 32'h8000) >= 12'h800) ? 8'hFF : 8'h00);
    run(200);
    rd_check(5'h1B, "pulse_hi", (saw_of(en_cnt, 32'h8000) >= 12'h800) ? 8'hFF : 8'h00);
    wr(5'd18, 8'h48);
    run(1);
    rd_check(5'h1B, "test_clr", 0);
    run(50);
    rd_check(5'h1B, "test_hold", 0);
    wr(5'd18, 8'h40);
    en_cnt = 0;
    run(300);
    rd_check(5'h1B, "test_rel", (saw_of(en_cnt, 32'h8000) >= 12'h800) ? 8'hFF : 8'h00);

    // Hard sync of voice 3 from voice 2 (FREQ 0x8000 > 0x1000)
    do_reset();
    wr(5'd7, 8'h00); wr(5'd8, 8'h80);
    wr(5'd14, 8'h00); wr(5'd15, 8'h10); wr(5'd18, 8'h22);
    run(255);
    rd_check(5'h1B, "sync_pre", saw_of(255, 32'h1000) >> 4);
    run(1);
    rd_check(5'h1B, "sync_clr", 0);
    run(44);
    rd_check(5'h1B, "sync_post", saw_of(44, 32'h1000) >> 4);
    reset_pulse_check("final_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
